// File: rtl/ysyx_23060096_imem_resp.sv
// Instruction-memory responder: valid/ready fetch port backed by a loadable word array.
// Optional macro YSYX_23060096_IMEM_RAND_DELAY_EN adds 0..3 pseudo-random wait cycles per fetch.
module ysyx_23060096_imem_resp #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] ERR_INST  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_inst,
   output logic        rsp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int unsigned AW = $clog2(DEPTH);
`ifdef YSYX_23060096_IMEM_RAND_DELAY_EN
   localparam int unsigned CW = 5;
`else
   localparam int unsigned CW = 4;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] lat_load;
   logic [31:0]   addr_q;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   fetch_word;
   logic          fetch_fault;
   logic [31:0]   ld_word;
   logic          ld_fault;

   // Word index is checked at full 32-bit width so addresses past the array never alias.
   always_comb begin
      fetch_word  = (addr_q - BASE_ADDR) >> 2;
      fetch_fault = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (fetch_word >= DEPTH);
      ld_word     = (ld_addr - BASE_ADDR) >> 2;
      ld_fault    = (ld_addr[1:0] != 2'b00) || (ld_addr < BASE_ADDR) || (ld_word >= DEPTH);
   end

`ifdef YSYX_23060096_IMEM_RAND_DELAY_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   always_comb begin
      lat_load = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
   end
`else
   always_comb begin
      lat_load = CW'(LATENCY - 1);
   end
`endif

   always_ff @(posedge clk) begin
      if (ld_en && !ld_fault) begin
         mem[ld_word[AW-1:0]] <= ld_data;
      end
   end

   // The accept edge always enters WAIT; RESP follows once the counter is exhausted,
   // which places the RESP-entry edge exactly LATENCY edges after the accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         rsp_inst <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  cnt    <= lat_load;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state    <= S_RESP;
                  rsp_err  <= fetch_fault;
                  rsp_inst <= fetch_fault ? ERR_INST : mem[fetch_word[AW-1:0]];
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_ysyx_23060096_imem_resp.sv
// Directed bench for ysyx_23060096_imem_resp: two instances (LATENCY 1 and 4) with a response scoreboard.
module tb_ysyx_23060096_imem_resp;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] ERRI = 32'hDEAD_BEEF;
   localparam int          LAT0 = 1;
   localparam int          LAT1 = 4;

   logic        clk;
   logic        rst;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_inst  [2];
   logic        rsp_err   [2];

   logic [32:0] exp_q [$];
   int n_tests = 0;
   int n_fail  = 0;

   ysyx_23060096_imem_resp #(
      .BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(LAT0), .ERR_INST(ERRI)
   ) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   ysyx_23060096_imem_resp #(
      .BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(LAT1), .ERR_INST(ERRI)
   ) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] ei, input logic ee,
                        input int hold, input bit race, input logic [31:0] race_data);
      int lat;
      int k;
      logic [32:0] e;
      lat = (d == 0) ? LAT0 : LAT1;
      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
      req_valid[d] = 1'b1;
      req_addr[d]  = a;
      exp_q.push_back({ee, ei});
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'h8000_0004;
      k = 0;
      while (k < 40 && rsp_valid[d] !== 1'b1) begin
         ld_en = race && (k == lat - 1);
         if (ld_en) begin
            ld_addr = a;
            ld_data = race_data;
         end
         @(negedge clk);
         k++;
      end
      ld_en = 1'b0;
      chk("rsp_valid_seen", 64'(rsp_valid[d]), 64'd1);
`ifdef YSYX_23060096_IMEM_RAND_DELAY_EN
      chk("latency_range", 64'(k >= lat && k <= lat + 3), 64'd1);
`else
      chk("latency", 64'(k), 64'(lat));
`endif
      e = exp_q.pop_front();
      for (int h = 0; h < hold; h++) begin
         chk("hold_req_ready", 64'(req_ready[d]), 64'd0);
         chk("hold_rsp_inst", 64'(rsp_inst[d]), 64'(e[31:0]));
         @(negedge clk);
         chk("hold_rsp_valid", 64'(rsp_valid[d]), 64'd1);
      end
      chk("rsp_inst", 64'(rsp_inst[d]), 64'(e[31:0]));
      chk("rsp_err", 64'(rsp_err[d]), 64'(e[32]));
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chk("post_rsp_valid", 64'(rsp_valid[d]), 64'd0);
      chk("post_req_ready", 64'(req_ready[d]), 64'd1);
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_req_ready", 64'(req_ready[i]), 64'd1);
         chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
         chk("rst_rsp_inst", 64'(rsp_inst[i]), 64'd0);
         chk("rst_rsp_err", 64'(rsp_err[i]), 64'd0);
      end
      rst = 1'b0;

      // stray rsp_ready while idle
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      chk("stray_ready_valid", 64'(rsp_valid[0]), 64'd0);
      chk("stray_ready_req_ready", 64'(req_ready[0]), 64'd1);

      // basic fetch and backpressure
      load(BASE, 32'h0000_0413);
      fetch(0, BASE, 32'h0000_0413, 1'b0, 0, 1'b0, '0);
      fetch(1, BASE, 32'h0000_0413, 1'b0, 5, 1'b0, '0);

      // faults and ignored loads
      load(BASE + 32'hFFC, 32'hCAFE_0001);
      load(BASE + 32'h4, 32'h1234_5678);
      load(32'h7FFF_FFFC, 32'hBAD0_0001);
      load(BASE + 32'h1000, 32'hBAD0_0002);
      load(BASE + 32'h6, 32'hBAD0_0003);
      fetch(0, BASE + 32'h2, ERRI, 1'b1, 0, 1'b0, '0);
      fetch(0, BASE + 32'h1000, ERRI, 1'b1, 2, 1'b0, '0);
      fetch(1, 32'h7FFF_FFFC, ERRI, 1'b1, 0, 1'b0, '0);
      fetch(0, 32'hFFFF_FFFC, ERRI, 1'b1, 0, 1'b0, '0);
      fetch(0, BASE + 32'hFFC, 32'hCAFE_0001, 1'b0, 0, 1'b0, '0);
      fetch(1, BASE, 32'h0000_0413, 1'b0, 0, 1'b0, '0);
      fetch(0, BASE + 32'h4, 32'h1234_5678, 1'b0, 0, 1'b0, '0);

`ifndef YSYX_23060096_IMEM_RAND_DELAY_EN
      // load on the RESP-entry edge returns the old word
      load(BASE, 32'h1111_1111);
      fetch(0, BASE, 32'h1111_1111, 1'b0, 0, 1'b1, 32'h2222_2222);
      fetch(0, BASE, 32'h2222_2222, 1'b0, 0, 1'b0, '0);
      load(BASE + 32'h8, 32'h3333_3333);
      fetch(1, BASE + 32'h8, 32'h3333_3333, 1'b0, 1, 1'b1, 32'h4444_4444);
      fetch(1, BASE + 32'h8, 32'h4444_4444, 1'b0, 0, 1'b0, '0);
`endif

      // reset while waiting abandons the request
      @(negedge clk);
      req_valid[1] = 1'b1; req_addr[1] = BASE + 32'h4;
      @(negedge clk);
      req_valid[1] = 1'b0;
      chk("mid_req_ready_wait", 64'(req_ready[1]), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_req_ready", 64'(req_ready[1]), 64'd1);
      chk("mid_rst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
      chk("mid_rst_rsp_inst", 64'(rsp_inst[1]), 64'd0);
      chk("mid_rst_rsp_err", 64'(rsp_err[1]), 64'd0);
      for (int i = 0; i < LAT1 + 2; i++) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", 64'(rsp_valid[1]), 64'd0);
      end
      fetch(1, BASE + 32'h4, 32'h1234_5678, 1'b0, 0, 1'b0, '0);

`ifdef YSYX_23060096_IMEM_RAND_DELAY_EN
      for (int i = 0; i < 100; i++) begin
         fetch(i % 2, BASE + 32'h4, 32'h1234_5678, 1'b0, 0, 1'b0, '0);
      end
`endif

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
